// File: rtl/wr_buf_pkg.sv
// Shared constants and types for the posted-write buffer.
package wr_buf_pkg;

    // Default number of queued stores.
    localparam int WB_DEPTH    = 4;
    // Byte-offset bits below the word address.
    localparam int WB_ADDR_LSB = 2;

    // Who owns the memory port in the current cycle.
    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_DRAIN = 2'd2
    } port_own_e;

endpackage

// File: rtl/wr_buf_if.sv
// CPU-side and memory-side bus signals of the write buffer.
// master: the CPU plus memory environment; slave: the buffer itself.
interface wr_buf_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] wb_cpu_addr;
    logic [DW-1:0] wb_cpu_wr_data;
    logic          wb_cpu_rd;
    logic          wb_cpu_wr;
    logic [DW-1:0] wb_cpu_rd_data;
    logic          wb_cpu_stall;
    logic [AW-1:0] wb_mem_addr;
    logic [DW-1:0] wb_mem_wr_data;
    logic          wb_mem_rd;
    logic          wb_mem_wr;
    logic [DW-1:0] wb_mem_rd_data;

    modport master (
        output wb_cpu_addr, wb_cpu_wr_data, wb_cpu_rd, wb_cpu_wr, wb_mem_rd_data,
        input  wb_cpu_rd_data, wb_cpu_stall, wb_mem_addr, wb_mem_wr_data,
        input  wb_mem_rd, wb_mem_wr
    );

    modport slave (
        input  wb_cpu_addr, wb_cpu_wr_data, wb_cpu_rd, wb_cpu_wr, wb_mem_rd_data,
        output wb_cpu_rd_data, wb_cpu_stall, wb_mem_addr, wb_mem_wr_data,
        output wb_mem_rd, wb_mem_wr
    );
endinterface

// File: rtl/wr_buf_fifo.sv
// Circular store queue: pointers, count, full/empty flags and a parallel
// address compare that returns the youngest matching entry.
module wr_buf_fifo
    import wr_buf_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int WAW   = 30,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enq,
    input  logic           deq,
    input  logic [WAW-1:0] enq_word,
    input  logic [DW-1:0]  enq_data,
    input  logic [WAW-1:0] look_word,
    output logic [WAW-1:0] head_word,
    output logic [DW-1:0]  head_data,
    output logic           full,
    output logic           empty,
    output logic           hit,
    output logic [DW-1:0]  hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [PW-1:0]  head_r;
    logic [PW-1:0]  tail_r;
    logic [CW-1:0]  count_r;
    logic [WAW-1:0] word_mem_r [DEPTH];
    logic [DW-1:0]  data_mem_r [DEPTH];
    logic [PW-1:0]  scan_idx_s;
    logic [PW-1:0]  hit_idx_s;
    logic           hit_s;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (enq) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
            if (deq) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Capture an accepted store in the tail slot (contents need no reset,
    // stale slots are masked by the count).
    always_ff @(posedge clk) begin
        if (enq) begin
            word_mem_r[tail_r] <= enq_word;
            data_mem_r[tail_r] <= enq_data;
        end
    end

    // Scan oldest-to-youngest so the last valid match is the youngest store.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = {PW{1'b0}};
        scan_idx_s = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx_s = head_r + PW'(i);
            if ((CW'(i) < count_r) && (word_mem_r[scan_idx_s] == look_word)) begin
                hit_s     = 1'b1;
                hit_idx_s = scan_idx_s;
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    assign hit       = hit_s;
    assign hit_data  = data_mem_r[hit_idx_s];
    assign head_word = word_mem_r[head_r];
    assign head_data = data_mem_r[head_r];
    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {CW{1'b0}});

endmodule

// File: rtl/wr_buf.sv
// Posted-write buffer: CPU stores complete immediately into a small queue
// that drains to memory whenever the port is not needed by a load miss.
// Loads that hit a queued store are forwarded from the youngest match.
module wr_buf
    import wr_buf_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic     wb_clk,
    input  logic     wb_rst_n,
    wr_buf_if.slave  bus,
    input  logic     wb_flush,
    output logic     wb_empty,
    output logic     wb_err
);

    localparam int WAW = AW - WB_ADDR_LSB;

    logic           access_s;
    logic           viol_s;
    logic           stall_s;
    logic           load_s;
    logic           store_s;
    logic           load_miss_s;
    logic           drain_s;
    logic           full_s;
    logic           empty_s;
    logic           hit_s;
    logic [WAW-1:0] head_word_s;
    logic [DW-1:0]  head_data_s;
    logic [DW-1:0]  hit_data_s;
    port_own_e      port_own_s;
    logic           err_r;

    wr_buf_fifo #(
        .DEPTH (DEPTH),
        .WAW   (WAW),
        .DW    (DW)
    ) u_fifo (
        .clk       (wb_clk),
        .rst_n     (wb_rst_n),
        .enq       (store_s),
        .deq       (drain_s),
        .enq_word  (bus.wb_cpu_addr[AW-1:WB_ADDR_LSB]),
        .enq_data  (bus.wb_cpu_wr_data),
        .look_word (bus.wb_cpu_addr[AW-1:WB_ADDR_LSB]),
        .head_word (head_word_s),
        .head_data (head_data_s),
        .full      (full_s),
        .empty     (empty_s),
        .hit       (hit_s),
        .hit_data  (hit_data_s)
    );

    // A full queue stalls even if it drains this cycle: no full-bypass.
    // A simultaneous rd+wr is served as a load and the store is dropped.
    assign access_s    = bus.wb_cpu_rd | bus.wb_cpu_wr;
    assign viol_s      = bus.wb_cpu_rd & bus.wb_cpu_wr;
    assign stall_s     = access_s & (full_s | wb_flush);
    assign load_s      = bus.wb_cpu_rd & ~stall_s;
    assign store_s     = bus.wb_cpu_wr & ~bus.wb_cpu_rd & ~stall_s;
    assign load_miss_s = load_s & ~hit_s;
    assign drain_s     = ~empty_s & (~load_miss_s | wb_flush | full_s);

    // Decide which requester owns the memory port this cycle.
    always_comb begin
        port_own_s = PORT_IDLE;
        if (drain_s) begin
            port_own_s = PORT_DRAIN;
        end else if (load_miss_s) begin
            port_own_s = PORT_LOAD;
        end else begin
            port_own_s = PORT_IDLE;
        end
    end

    // Drive the memory port from the owner; idle keeps address at zero.
    always_comb begin
        bus.wb_mem_addr    = {AW{1'b0}};
        bus.wb_mem_wr_data = {DW{1'b0}};
        bus.wb_mem_rd      = 1'b0;
        bus.wb_mem_wr      = 1'b0;
        case (port_own_s)
            PORT_DRAIN: begin
                bus.wb_mem_addr    = {head_word_s, {WB_ADDR_LSB{1'b0}}};
                bus.wb_mem_wr_data = head_data_s;
                bus.wb_mem_wr      = 1'b1;
            end
            PORT_LOAD: begin
                bus.wb_mem_addr = bus.wb_cpu_addr;
                bus.wb_mem_rd   = 1'b1;
            end
            default: begin
                bus.wb_mem_addr = {AW{1'b0}};
            end
        endcase
    end

    // Load data: forwarded queue entry on a hit, memory data on a miss.
    always_comb begin
        bus.wb_cpu_rd_data = {DW{1'b0}};
        if (load_s && hit_s) begin
            bus.wb_cpu_rd_data = hit_data_s;
        end else if (load_miss_s) begin
            bus.wb_cpu_rd_data = bus.wb_mem_rd_data;
        end else begin
            bus.wb_cpu_rd_data = {DW{1'b0}};
        end
    end

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            err_r <= 1'b0;
        end else if (viol_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.wb_cpu_stall = stall_s;
    assign wb_empty         = empty_s;
    assign wb_err           = err_r;

endmodule

// File: tb/tb_wr_buf.sv
// Randomized scoreboard bench for wr_buf with a queue-based reference model.
module tb_wr_buf;
    import wr_buf_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct packed {
        logic [29:0] word;
        logic [31:0] data;
    } st_t;

    typedef struct packed {
        logic        stall;
        logic        rd_chk;
        logic [31:0] rd_data;
        logic        mem_wr;
        logic        mem_rd;
        logic [31:0] mem_addr;
        logic [31:0] mem_wr_data;
        logic        empty;
        logic        err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic empty;
    logic err;

    int checks = 0;
    int errors = 0;

    st_t         ref_q[$];
    exp_t        sb_q[$];
    logic [31:0] ref_mem [bit [29:0]];
    logic        ref_err = 1'b0;

    logic [31:0] tb_mem  [0:1023];
    bit          written [0:1023];

    wr_buf_if #(.AW(AW), .DW(DW)) bus ();

    wr_buf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .wb_clk   (clk),
        .wb_rst_n (rst_n),
        .bus      (bus),
        .wb_flush (flush),
        .wb_empty (empty),
        .wb_err   (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [9:0] idx);
        if (idx == 10'h080) return 32'h1234_5678;
        return {16'hC0DE, 6'd0, idx};
    endfunction

    function automatic logic [31:0] mem_val(input logic [9:0] idx);
        return written[idx] ? tb_mem[idx] : init_val(idx);
    endfunction

    function automatic logic [31:0] ref_read(input logic [29:0] w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return init_val(w[9:0]);
    endfunction

    // Memory emulation: writes on the rising edge, reads combinationally.
    always @(posedge clk) begin
        if (bus.wb_mem_wr) begin
            tb_mem[bus.wb_mem_addr[11:2]]  <= bus.wb_mem_wr_data;
            written[bus.wb_mem_addr[11:2]] <= 1'b1;
        end
    end

    always_comb bus.wb_mem_rd_data = mem_val(bus.wb_mem_addr[11:2]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, predict the outputs, then advance the model.
    task automatic step(input bit rd, input bit wr, input bit fl,
                        input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        st_t  h;
        int   hit_i;
        bit   full, stall, load, miss, drain;
        @(posedge clk);
        #1;
        rst_n              = 1'b1;
        bus.wb_cpu_rd      = rd;
        bus.wb_cpu_wr      = wr;
        bus.wb_cpu_addr    = addr;
        bus.wb_cpu_wr_data = data;
        flush              = fl;
        full  = (ref_q.size() == DEPTH);
        stall = (rd || wr) && (full || fl);
        load  = rd && !stall;
        miss  = 1'b0;
        e = '0;
        e.stall = stall;
        e.empty = (ref_q.size() == 0);
        e.err   = ref_err;
        if (load) begin
            hit_i = -1;
            foreach (ref_q[i]) if (ref_q[i].word == addr[31:2]) hit_i = i;
            miss      = (hit_i < 0);
            e.rd_chk  = 1'b1;
            e.rd_data = miss ? ref_read(addr[31:2]) : ref_q[hit_i].data;
        end
        drain = (ref_q.size() > 0) && (!miss || fl || full);
        if (drain) begin
            e.mem_wr      = 1'b1;
            e.mem_addr    = {ref_q[0].word, 2'b00};
            e.mem_wr_data = ref_q[0].data;
        end else if (miss) begin
            e.mem_rd   = 1'b1;
            e.mem_addr = addr;
        end
        sb_q.push_back(e);
        if (rd && wr) ref_err = 1'b1;
        if (drain) begin
            h = ref_q.pop_front();
            ref_mem[h.word] = h.data;
        end
        if (wr && !rd && !stall) ref_q.push_back('{word: addr[31:2], data: data});
    endtask

    // Assert reset between edges for one cycle; queued stores are lost.
    task automatic reset_cycle();
        exp_t e;
        @(posedge clk);
        #1;
        bus.wb_cpu_rd = 1'b0;
        bus.wb_cpu_wr = 1'b0;
        flush         = 1'b0;
        #1;
        rst_n = 1'b0;
        ref_q.delete();
        ref_err = 1'b0;
        e = '0;
        e.empty  = 1'b1;
        e.rd_chk = 1'b1;
        sb_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("stall", bus.wb_cpu_stall, e.stall);
                chk("mem_wr", bus.wb_mem_wr, e.mem_wr);
                chk("mem_rd", bus.wb_mem_rd, e.mem_rd);
                chk("mem_addr", bus.wb_mem_addr, e.mem_addr);
                if (e.mem_wr) chk("mem_wr_data", bus.wb_mem_wr_data, e.mem_wr_data);
                if (e.rd_chk) chk("rd_data", bus.wb_cpu_rd_data, e.rd_data);
                chk("empty", empty, e.empty);
                chk("err", err, e.err);
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          r;
        bus.wb_cpu_rd      = 1'b0;
        bus.wb_cpu_wr      = 1'b0;
        bus.wb_cpu_addr    = 32'd0;
        bus.wb_cpu_wr_data = 32'd0;
        repeat (2) @(posedge clk);

        // Reset state.
        reset_cycle();
        @(negedge clk);
        chk("reset_empty", empty, 1'b1);

        // Forwarding of the youngest store, then drain order leaves it in memory.
        step(1'b0, 1'b1, 1'b0, 32'h100, 32'hAAAA_0001);
        step(1'b0, 1'b1, 1'b0, 32'h100, 32'hBBBB_0002);
        step(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        chk("fwd_data", bus.wb_cpu_rd_data, 32'hBBBB_0002);
        chk("fwd_mem_rd", bus.wb_mem_rd, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("fwd_mem", mem_val(10'h040), 32'hBBBB_0002);

        // Load miss takes the port ahead of the drain.
        step(1'b0, 1'b1, 1'b0, 32'h104, 32'h0000_0055);
        step(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        chk("miss_rd", bus.wb_mem_rd, 1'b1);
        chk("miss_wr", bus.wb_mem_wr, 1'b0);
        chk("miss_data", bus.wb_cpu_rd_data, 32'h1234_5678);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("miss_then_drain", bus.wb_mem_addr, 32'h104);

        // Flush blocks a pending store and drains the queue.
        step(1'b0, 1'b1, 1'b0, 32'h108, 32'h0000_0108);
        step(1'b0, 1'b1, 1'b1, 32'h10C, 32'h0000_010C);
        @(negedge clk);
        chk("flush_stall", bus.wb_cpu_stall, 1'b1);
        chk("flush_drain", bus.wb_mem_wr, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h10C, 32'h0000_010C);
        @(negedge clk);
        chk("flush_empty", empty, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h10C, 32'h0000_010C);

        // Protocol violation: served as a load, store dropped, sticky error.
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("viol_err_sticky", err, 1'b1);

        // Reset mid-traffic discards queued stores.
        step(1'b0, 1'b1, 1'b0, 32'h110, 32'h0000_F00D);
        reset_cycle();
        @(negedge clk);
        chk("midrst_empty", empty, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("midrst_no_write", mem_val(10'h044), init_val(10'h044));

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_cycle();
            end else begin
                a = 32'h100 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
                r = $urandom_range(0, 19);
                if (r < 8)       step(1'b0, 1'b1, ($urandom_range(0, 7) == 0), a, $urandom);
                else if (r < 15) step(1'b1, 1'b0, ($urandom_range(0, 7) == 0), a, $urandom);
                else if (r < 19) step(1'b0, 1'b0, ($urandom_range(0, 7) == 0), a, $urandom);
                else             step(1'b1, 1'b1, 1'b0, a, $urandom);
            end
        end

        // Final flush and memory image comparison.
        for (int n = 0; n < 4 * DEPTH && ref_q.size() > 0; n++) step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        for (int w = 16'h40; w < 16'h50; w++) chk("mem_image", mem_val(10'(w)), ref_read(30'(w)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
